// File: rtl/multicycle_controller.sv
// Multicycle ARM-subset control unit: walks each instruction through fetch, decode,
// execute, memory and writeback, and owns the NZCV register and condition checks.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  State
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t     state, state_next;
    logic [3:0] flags;
    logic       cond_ok_exec;

    logic [3:0] cond, rd, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       unused_rn;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign funct = Instr[13:8];
    assign rd    = Instr[3:0];
    assign cmd   = funct[4:1];
    // Rn only steers the register file read port in the datapath.
    assign unused_rn = ^Instr[7:4];

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0:    cond_check = z;
            4'h1:    cond_check = !z;
            4'h2:    cond_check = cy;
            4'h3:    cond_check = !cy;
            4'h4:    cond_check = n;
            4'h5:    cond_check = !n;
            4'h6:    cond_check = v;
            4'h7:    cond_check = !v;
            4'h8:    cond_check = cy && !z;
            4'h9:    cond_check = !cy || z;
            4'hA:    cond_check = (n == v);
            4'hB:    cond_check = (n != v);
            4'hC:    cond_check = !z && (n == v);
            4'hD:    cond_check = z || (n != v);
            4'hE:    cond_check = 1'b1;
            default: cond_check = 1'b0;
        endcase
    endfunction

    logic       cond_ex, is_add, is_sub, is_and, is_orr, is_cmp, supported, wb_en;
    logic [1:0] alu_ctrl, flag_w;

    always_comb begin
        is_add    = (cmd == 4'b0100);
        is_sub    = (cmd == 4'b0010);
        is_and    = (cmd == 4'b0000);
        is_orr    = (cmd == 4'b1100);
        is_cmp    = (cmd == 4'b1010);
        supported = is_add || is_sub || is_and || is_orr || is_cmp;
        alu_ctrl  = 2'b00;
        if (is_sub || is_cmp)
            alu_ctrl = 2'b01;
        else if (is_and)
            alu_ctrl = 2'b10;
        else if (is_orr)
            alu_ctrl = 2'b11;
        flag_w = 2'b00;
        if (is_cmp)
            flag_w = 2'b11;
        else if (supported)
            flag_w = {funct[0], funct[0] && (is_add || is_sub)};
    end

    assign cond_ex = cond_check(cond, flags);
    // Writeback uses the verdict taken before this instruction's own flag update.
    assign wb_en   = cond_ok_exec && supported && !is_cmp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= state_t'(RESET_STATE);
            flags        <= 4'b0000;
            cond_ok_exec <= 1'b0;
        end else begin
            state <= state_next;
            if (state == EXECUTER || state == EXECUTEI) begin
                cond_ok_exec <= cond_ex;
                if (cond_ex && flag_w[1])
                    flags[3:2] <= ALUFlags[3:2];
                if (cond_ex && flag_w[0])
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        RegWrite   = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
                state_next = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01:   state_next = MEMADR;
                    2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b10:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                if (rd == 4'hF)
                    PCWrite = cond_ex;
                else
                    RegWrite = cond_ex;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = cond_ex;
                state_next = (!cond_ex || MemReady) ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUControl = alu_ctrl;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_ctrl;
                state_next = ALUWB;
            end
            ALUWB: begin
                if (rd == 4'hF)
                    PCWrite = wb_en;
                else
                    RegWrite = wb_en;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: state_next = FETCH;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign State  = state;
    assign ImmSrc = op;
    assign RegSrc = {(op == 2'b01) && !funct[0], (op == 2'b10)};
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction scenarios plus a random
// instruction stream checked against an instruction-level architectural model.
module tb_multicycle_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  State;

    multicycle_controller #(.RESET_STATE(4'd0)) dut (
        .clk(clk), .rst(rst), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] EN_F  = 4'b1100;
    localparam logic [3:0] EN_PC = 4'b1000;
    localparam logic [3:0] EN_MW = 4'b0010;
    localparam logic [3:0] EN_RW = 4'b0001;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  obs_st  [32];
    logic [3:0]  obs_en  [32];
    logic [7:0]  obs_sel [32];
    logic [3:0]  obs_dec [32];
    logic [3:0]  ex_st   [32];
    logic [3:0]  ex_en   [32];
    logic [7:0]  ex_sel  [32];
    logic [31:0] ex_mr;
    int          ex_n;
    logic [3:0]  mflags;

    // Enables packed {PCWrite,IRWrite,MemWrite,RegWrite};
    // selects packed {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}.
    task automatic drive(input logic [31:0] ins, input logic [3:0] af, input int n,
                         input logic [31:0] mr);
        for (int i = 0; i < n; i++) begin
            Instr    = ins[31:12];
            ALUFlags = af;
            MemReady = mr[i];
            @(negedge clk);
            obs_st[i]  = State;
            obs_en[i]  = {PCWrite, IRWrite, MemWrite, RegWrite};
            obs_sel[i] = {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};
            obs_dec[i] = {ImmSrc, RegSrc};
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sel_of(input logic [3:0] st, input logic [1:0] ac);
        case (st)
            4'd0, 4'd1: return 8'b0_10_1_10_00;
            4'd2:       return 8'b0_00_0_01_00;
            4'd3, 4'd5: return 8'b1_00_0_00_00;
            4'd4:       return 8'b0_01_0_00_00;
            4'd6:       return {6'b0_00_0_00, ac};
            4'd7:       return {6'b0_00_0_01, ac};
            4'd9:       return 8'b0_10_0_01_00;
            default:    return 8'b0_00_0_00_00;
        endcase
    endfunction

    function automatic void add_step(input logic [3:0] st, input logic [3:0] en,
                                     input logic mr, input logic [1:0] ac);
        ex_st[ex_n]  = st;
        ex_en[ex_n]  = en;
        ex_sel[ex_n] = sel_of(st, ac);
        ex_mr[ex_n]  = mr;
        ex_n++;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic test_reset();
        rst = 1'b1; MemReady = 1'b1; Instr = 20'hE0821; ALUFlags = 4'h0;
        @(negedge clk); @(negedge clk);
        n_vec++; if (State !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", State); end
        n_vec++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            n_err++; $display("FAIL reset_enables: got %b expected 0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'h0A000000, 4'h0, 3, 32'h7);
        n_vec++; if (obs_en[2] !== 4'b0000) begin n_err++; $display("FAIL reset_flags_beq: got %b expected 0000", obs_en[2]); end
    endtask

    task automatic test_add();
        logic [3:0] es [5];
        logic [3:0] ee [5];
        es = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        ee = '{EN_F, 4'b0000, 4'b0000, EN_RW, 4'b0000};
        drive(32'hE0821003, 4'h0, 5, 32'h0000000F);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (obs_st[i] !== es[i]) begin n_err++; $display("FAIL add_state[%0d]: got %0d expected %0d", i, obs_st[i], es[i]); end
            n_vec++; if (obs_en[i] !== ee[i]) begin n_err++; $display("FAIL add_enables[%0d]: got %b expected %b", i, obs_en[i], ee[i]); end
        end
        n_vec++; if (obs_sel[0] !== 8'b0_10_1_10_00) begin n_err++; $display("FAIL add_fetch_sel: got %b expected 01011000", obs_sel[0]); end
        n_vec++; if (obs_sel[2] !== 8'b0_00_0_00_00) begin n_err++; $display("FAIL add_exec_sel: got %b expected 00000000", obs_sel[2]); end
    endtask

    task automatic test_flags_branch();
        drive(32'hE2500001, 4'b0100, 4, 32'hF);
        n_vec++; if (obs_st[2] !== 4'd7) begin n_err++; $display("FAIL subs_state: got %0d expected 7", obs_st[2]); end
        n_vec++; if (obs_sel[2][1:0] !== 2'b01) begin n_err++; $display("FAIL subs_aluctl: got %b expected 01", obs_sel[2][1:0]); end
        n_vec++; if (obs_en[3] !== EN_RW) begin n_err++; $display("FAIL subs_wb: got %b expected %b", obs_en[3], EN_RW); end
        drive(32'h1AFFFFFD, 4'h0, 3, 32'h7);
        n_vec++; if (obs_st[2] !== 4'd9) begin n_err++; $display("FAIL bne_state: got %0d expected 9", obs_st[2]); end
        n_vec++; if (obs_en[2] !== 4'b0000) begin n_err++; $display("FAIL bne_not_taken: got %b expected 0000", obs_en[2]); end
        drive(32'hE2500001, 4'b0000, 4, 32'hF);
        drive(32'h1AFFFFFD, 4'h0, 3, 32'h7);
        n_vec++; if (obs_en[2] !== EN_PC) begin n_err++; $display("FAIL bne_taken: got %b expected %b", obs_en[2], EN_PC); end
        n_vec++; if (obs_sel[2] !== 8'b0_10_0_01_00) begin n_err++; $display("FAIL branch_sel: got %b expected 01000100", obs_sel[2]); end
    endtask

    task automatic test_ldr_wait();
        logic [3:0] es [9];
        es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        drive(32'hE5921004, 4'h0, 9, 32'h41);
        for (int i = 0; i < 9; i++) begin
            n_vec++; if (obs_st[i] !== es[i]) begin n_err++; $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, obs_st[i], es[i]); end
        end
        n_vec++; if (obs_sel[3][7] !== 1'b1) begin n_err++; $display("FAIL ldr_adrsrc: got %b expected 1", obs_sel[3][7]); end
        n_vec++; if (obs_sel[7][6:5] !== 2'b01) begin n_err++; $display("FAIL ldr_resultsrc: got %b expected 01", obs_sel[7][6:5]); end
        n_vec++; if (obs_en[7] !== EN_RW) begin n_err++; $display("FAIL ldr_wb: got %b expected %b", obs_en[7], EN_RW); end
        n_vec++; if (obs_en[8] !== 4'b0000) begin n_err++; $display("FAIL ldr_after: got %b expected 0000", obs_en[8]); end
    endtask

    task automatic test_str_condfail();
        logic [3:0] es [5];
        es = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        drive(32'h05821004, 4'h0, 5, 32'h1);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (obs_st[i] !== es[i]) begin n_err++; $display("FAIL str_state[%0d]: got %0d expected %0d", i, obs_st[i], es[i]); end
        end
        n_vec++; if (obs_en[3] !== 4'b0000) begin n_err++; $display("FAIL str_memwrite: got %b expected 0000", obs_en[3]); end
        n_vec++; if (obs_dec[3] !== 4'b01_10) begin n_err++; $display("FAIL str_immsrc_regsrc: got %b expected 0110", obs_dec[3]); end
    endtask

    task automatic test_cmp();
        drive(32'hE3500000, 4'b0110, 4, 32'hF);
        n_vec++; if (obs_st[2] !== 4'd7 || obs_st[3] !== 4'd8) begin
            n_err++; $display("FAIL cmp_states: got %0d,%0d expected 7,8", obs_st[2], obs_st[3]); end
        n_vec++; if (obs_sel[2][1:0] !== 2'b01) begin n_err++; $display("FAIL cmp_aluctl: got %b expected 01", obs_sel[2][1:0]); end
        n_vec++; if (obs_en[3] !== 4'b0000) begin n_err++; $display("FAIL cmp_regwrite: got %b expected 0000", obs_en[3]); end
        drive(32'h0A000000, 4'h0, 3, 32'h7);
        n_vec++; if (obs_en[2] !== EN_PC) begin n_err++; $display("FAIL cmp_beq: got %b expected %b", obs_en[2], EN_PC); end
        drive(32'h4A000000, 4'h0, 3, 32'h7);
        n_vec++; if (obs_en[2] !== 4'b0000) begin n_err++; $display("FAIL cmp_bmi: got %b expected 0000", obs_en[2]); end
    endtask

    task automatic test_async_reset();
        drive(32'hE5921004, 4'h0, 4, 32'h1);
        n_vec++; if (obs_st[3] !== 4'd3) begin n_err++; $display("FAIL arst_pre_state: got %0d expected 3", obs_st[3]); end
        MemReady = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_vec++; if (State !== 4'd0) begin n_err++; $display("FAIL arst_state: got %0d expected 0", State); end
        n_vec++; if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
            n_err++; $display("FAIL arst_enables: got %b expected 0000", {PCWrite, IRWrite, MemWrite, RegWrite}); end
        @(posedge clk); #1;
        rst = 1'b0;
        drive(32'hE0821003, 4'h0, 4, 32'hF);
        n_vec++; if (obs_st[0] !== 4'd0 || obs_sel[0][7] !== 1'b0) begin
            n_err++; $display("FAIL arst_resume: got state %0d adrsrc %b expected 0 0", obs_st[0], obs_sel[0][7]); end
        n_vec++; if (obs_en[0] !== EN_F || obs_en[3] !== EN_RW) begin
            n_err++; $display("FAIL arst_resume_en: got %b,%b expected %b,%b", obs_en[0], obs_en[3], EN_F, EN_RW); end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [3:0]  af, cond, rd, cmd, wb;
        logic [1:0]  op, ac, fw;
        logic [5:0]  funct;
        logic        ok, sup, cmp;
        int          wf, wm;
        mflags = 4'h0;
        for (int k = 0; k < 80; k++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) == 0) ins[31:28] = 4'hE;
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: ins[24:21] = 4'b0100;
                    1: ins[24:21] = 4'b0010;
                    2: ins[24:21] = 4'b0000;
                    3: ins[24:21] = 4'b1100;
                    default: ins[24:21] = 4'b1010;
                endcase
            end
            cond  = ins[31:28];
            op    = ins[27:26];
            funct = ins[25:20];
            rd    = ins[15:12];
            cmd   = funct[4:1];
            af    = 4'($urandom);
            wf    = $urandom_range(0, 2);
            wm    = $urandom_range(0, 2);
            ok    = cond_holds(cond, mflags);
            wb    = (rd == 4'hF) ? EN_PC : EN_RW;
            ex_n  = 0;
            ex_mr = 32'h0;
            for (int i = 0; i < wf; i++) add_step(4'd0, 4'b0000, 1'b0, 2'b00);
            add_step(4'd0, EN_F, 1'b1, 2'b00);
            add_step(4'd1, 4'b0000, rnd_bit(), 2'b00);
            case (op)
                2'b01: begin
                    add_step(4'd2, 4'b0000, rnd_bit(), 2'b00);
                    if (funct[0]) begin
                        for (int i = 0; i < wm; i++) add_step(4'd3, 4'b0000, 1'b0, 2'b00);
                        add_step(4'd3, 4'b0000, 1'b1, 2'b00);
                        add_step(4'd4, ok ? wb : 4'b0000, rnd_bit(), 2'b00);
                    end else if (ok) begin
                        for (int i = 0; i < wm; i++) add_step(4'd5, EN_MW, 1'b0, 2'b00);
                        add_step(4'd5, EN_MW, 1'b1, 2'b00);
                    end else begin
                        add_step(4'd5, 4'b0000, rnd_bit(), 2'b00);
                    end
                end
                2'b00: begin
                    cmp = (cmd == 4'b1010);
                    sup = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
                          (cmd == 4'b1100) || cmp;
                    case (cmd)
                        4'b0010, 4'b1010: ac = 2'b01;
                        4'b0000:          ac = 2'b10;
                        4'b1100:          ac = 2'b11;
                        default:          ac = 2'b00;
                    endcase
                    add_step(funct[5] ? 4'd7 : 4'd6, 4'b0000, rnd_bit(), ac);
                    add_step(4'd8, (ok && sup && !cmp) ? wb : 4'b0000, rnd_bit(), 2'b00);
                    if (ok && sup) begin
                        fw = cmp ? 2'b11 : {funct[0], funct[0] && (cmd == 4'b0100 || cmd == 4'b0010)};
                        if (fw[1]) mflags[3:2] = af[3:2];
                        if (fw[0]) mflags[1:0] = af[1:0];
                    end
                end
                2'b10: add_step(4'd9, ok ? EN_PC : 4'b0000, rnd_bit(), 2'b00);
                default: ;
            endcase
            drive(ins, af, ex_n, ex_mr);
            for (int i = 0; i < ex_n; i++) begin
                n_vec++; if (obs_st[i] !== ex_st[i]) begin n_err++;
                    $display("FAIL rnd_state k=%0d[%0d] ins=%h: got %0d expected %0d", k, i, ins, obs_st[i], ex_st[i]); end
                n_vec++; if (obs_en[i] !== ex_en[i]) begin n_err++;
                    $display("FAIL rnd_enables k=%0d[%0d] ins=%h: got %b expected %b", k, i, ins, obs_en[i], ex_en[i]); end
                n_vec++; if (obs_sel[i] !== ex_sel[i]) begin n_err++;
                    $display("FAIL rnd_selects k=%0d[%0d] ins=%h: got %b expected %b", k, i, ins, obs_sel[i], ex_sel[i]); end
                n_vec++; if (obs_dec[i] !== {op, (op == 2'b01) && !funct[0], op == 2'b10}) begin n_err++;
                    $display("FAIL rnd_decode k=%0d[%0d] ins=%h: got %b expected %b", k, i, ins, obs_dec[i],
                             {op, (op == 2'b01) && !funct[0], op == 2'b10}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_flags_branch();
        test_ldr_wait();
        test_str_condfail();
        test_cmp();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset processor. It replaces the single-cycle decoder/condition-logic pair with a state machine.
- Each instruction is sequenced through fetch, decode, execute, memory and writeback steps over a shared ALU and a unified memory.
- The block holds the NZCV flag register and conditional-execution logic internally.
- It sits between the instruction register and memory handshake on one side and the multicycle datapath's mux selects and write enables on the other.

Parameters:
- RESET_STATE, 4'd0, state code loaded on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- Instr  in  20  Instr[31:12] from the instruction register; stable from the cycle after IRWrite
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load enable
- ResultSrc  out  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  ALU A select: 0=RD1, 1=PC
- ALUSrcB  out  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- RegWrite  out  1  register file write enable
- ImmSrc  out  2  immediate format, equal to Op
- RegSrc  out  2  [0]: RA1=R15 for branch; [1]: RA2=Rd for STR
- State  out  4  current state code, for debug

Behaviour:
- Decode fields:
  - Op = Instr[27:26]; Funct = Instr[25:20]; Rd = Instr[15:12]; Cond = Instr[31:28].
  - ImmSrc and RegSrc are combinational from Instr in every state.
- States (code): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9.
  - Codes 10-15 are illegal and go to FETCH on the next cycle with all outputs deasserted.
- Reset:
  - State = FETCH; flag register = 0000.
  - While rst is high, all write enables (PCWrite, IRWrite, MemWrite, RegWrite) = 0.
  - Mid-instruction reset abandons the instruction with no partial writes.
- Default outputs: all enables 0, selects 0, ALUControl = ADD.
- FETCH:
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Hold state while MemReady=0.
  - In the MemReady=1 cycle: IRWrite=1 and PCWrite=1 for exactly that cycle, then go to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8). Next state:
  - Op=01 -> MEMADR.
  - Op=00 with Funct[5]=1 -> EXECUTEI.
  - Op=00 with Funct[5]=0 -> EXECUTER.
  - Op=10 -> BRANCH.
  - Op=11 -> FETCH (NOP).
- MEMADR:
  - ALUSrcB=01, ADD.
  - Next state is MEMREAD if Funct[0]=1 (LDR), else MEMWRITE.
- MEMREAD: AdrSrc=1; hold until MemReady; then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx; then go to FETCH.
- MEMWRITE:
  - AdrSrc=1; MemWrite=CondEx, held until MemReady; then go to FETCH.
  - If CondEx=0, go to FETCH immediately, ignoring MemReady.
- EXECUTER / EXECUTEI:
  - ALUSrcB = 00 / 01 respectively.
  - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB). Any other code gives ADD with writes suppressed.
  - Next state: ALUWB.
- ALUWB:
  - ResultSrc=00.
  - RegWrite = CondEx and command is not CMP and command is supported.
  - If Rd=15: PCWrite replaces RegWrite.
  - Next state: FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx; then go to FETCH.
- MEMWB with Rd=15 behaves the same as ALUWB with Rd=15: PCWrite replaces RegWrite.
- Flags:
  - FlagW = {S, S and (ADD, SUB or CMP)}, where S = Funct[0]. CMP forces FlagW=11.
  - At the end of the EXECUTE cycle, if CondEx=1: FlagW[1] loads N and Z; FlagW[0] loads C and V.
- CondEx is evaluated combinationally against the registered flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; Cond=1111 gives 0.
- A failed condition still walks every state. Only the write enables and flag updates are gated.
- Cycle counts with MemReady=1 always: data-processing 4, LDR 5, STR 4, B 3, NOP 2.

Test Plan:
- ADD R1,R2,R3 (0xE0821003): States 0,1,6,8,0; RegWrite=1 in ALUWB only; IRWrite and PCWrite each pulse once, in FETCH.
- SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0100, then BNE (0x1AFFFFFD): flags become 0100; BRANCH has PCWrite=0; re-run with ALUFlags=0000 and PCWrite=1.
- LDR R1,[R2,#4] (0xE5921004), MemReady low 3 cycles in MEMREAD: State holds at 3 for 3 cycles; MEMWB has ResultSrc=01 and RegWrite=1; 8 cycles total.
- STR (0xE5821004) with Cond=0000 and Z=0: MEMWRITE has MemWrite=0, goes to FETCH next cycle, RegSrc=10.
- CMP R0,#0 (0xE3500000) with ALUFlags=0110: RegWrite=0; flags become 0110.
- rst asserted asynchronously in MEMREAD: State=0 immediately with enables 0; after release, fetch resumes with AdrSrc=0.
